// File: rtl/sym_ex_sched.sv
// Round-robin front-end that shares one symbolic-execution program datapath between NREQ requesters.
// The winning requester's operands are latched, the program walks one location per cycle, and done/hit report whether L7 was reached.
module sym_ex_sched #(
    parameter int W    = 8,
    parameter int NREQ = 2,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ*W-1:0] c_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [OW-1:0]     owner,
    output logic [W-1:0]      z_out
);

    // state  | meaning
    // IDLE   | waiting for a request, arbitration active
    // L0     | program entry
    // L1     | X <= 3 when a != 0
    // L2     | branch on b < 5
    // L3     | Y assignment
    // L4     | Z <= 2
    // L5     | evaluate X+Y == 4
    // TERM   | report done/hit, grant still held
    typedef enum logic [2:0] {
        S_IDLE, S_L0, S_L1, S_L2, S_L3, S_L4, S_L5, S_TERM
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_r, b_r, c_r;
    logic [W-1:0]  x_r, y_r, z_r;
    logic [W-1:0]  sum;
    logic          hit_r;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] pick_idx;
    logic          pick_found;

    // First set request searching upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req[(int'(rr_ptr) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = OW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_L0;
            S_L0:    state_nxt = S_L1;
            S_L1:    state_nxt = S_L2;
            S_L2:    state_nxt = (b_r < W'(5)) ? S_L3 : S_L5;
            S_L3:    state_nxt = S_L4;
            S_L4:    state_nxt = S_L5;
            S_L5:    state_nxt = S_TERM;
            S_TERM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Carry out of the add is dropped so the compare sees only the W-bit sum.
    assign sum = x_r + y_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            hit_r  <= 1'b0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_found) begin
                    a_r    <= a_in[pick_idx*W +: W];
                    b_r    <= b_in[pick_idx*W +: W];
                    c_r    <= c_in[pick_idx*W +: W];
                    x_r    <= '0;
                    y_r    <= '0;
                    z_r    <= '0;
                    hit_r  <= 1'b0;
                    owner  <= pick_idx;
                    rr_ptr <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                end
                S_L1: if (a_r != '0) x_r <= W'(3);
                S_L3: y_r <= (a_r == '0 && c_r != '0) ? W'(2) : c_r;
                S_L4: z_r <= W'(2);
                S_L5: hit_r <= (sum == W'(4));
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (state != S_IDLE) gnt[owner] = 1'b1;
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_TERM);
    assign hit   = done & hit_r;
    assign z_out = z_r;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_busy:  assert property (@(posedge clk) disable iff (!rst_n) (!done || busy));
    a_hit_done:   assert property (@(posedge clk) disable iff (!rst_n) (!hit || done));
    a_busy_gnt:   assert property (@(posedge clk) disable iff (!rst_n) (busy == (gnt != '0)));

endmodule

// File: tb/tb_sym_ex_sched.sv
// Scoreboard bench for sym_ex_sched: each job pushes its predicted result, the monitor pops it on done.
module tb_sym_ex_sched;
    localparam int W    = 8;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0, b_in = '0, c_in = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy, done, hit;
    logic              owner;
    logic [W-1:0]      z_out;

    sym_ex_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .gnt(gnt), .busy(busy), .done(done), .hit(hit), .owner(owner), .z_out(z_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         own;
        logic       hit;
        logic [7:0] z;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0, prev_busy = 1'b0, prev_owner = 1'b0;

    // Reference program: long path when b<5 occupies 7 busy cycles, short path 5.
    function automatic exp_t model(int own, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        exp_t       e;
        logic [7:0] x, y, s;
        x = (a != 0) ? 8'd3 : 8'd0;
        if (b < 8'd5) begin
            y     = (a == 0 && c != 0) ? 8'd2 : c;
            e.z   = 8'd2;
            e.lat = 7;
        end else begin
            y     = 8'd0;
            e.z   = 8'd0;
            e.lat = 5;
        end
        s     = x + y;
        e.hit = (s == 8'd4);
        e.own = own;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            n_total++;
            if ($countones(gnt) > 1 || (busy != (gnt != 0)))
                $display("FAIL gnt_onehot: gnt=%b busy=%b", gnt, busy);
            else n_pass++;
            n_total++;
            if (hit && !done) $display("FAIL hit_without_done: hit=%b done=%b", hit, done);
            else n_pass++;
            if (prev_done) begin
                n_total++;
                if (busy !== 1'b0) $display("FAIL term_gap: busy=%b required 0", busy);
                else n_pass++;
            end
            if (prev_busy && busy && !prev_done) begin
                n_total++;
                if (owner !== prev_owner) $display("FAIL owner_stable: owner=%0d required %0d", owner, prev_owner);
                else n_pass++;
            end
            if (done) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL unexpected_done: done=1 with empty scoreboard");
                else begin
                    exp_t e;
                    logic [NREQ-1:0] g_exp;
                    n_pass++;
                    e = sb.pop_front();
                    g_exp = '0;
                    g_exp[e.own] = 1'b1;
                    n_total++;
                    if (owner !== e.own[0]) $display("FAIL sb_owner: owner=%0d required %0d", owner, e.own);
                    else n_pass++;
                    n_total++;
                    if (gnt !== g_exp) $display("FAIL sb_gnt: gnt=%b required %b", gnt, g_exp);
                    else n_pass++;
                    n_total++;
                    if (hit !== e.hit) $display("FAIL sb_hit: hit=%b required %b", hit, e.hit);
                    else n_pass++;
                    n_total++;
                    if (z_out !== e.z) $display("FAIL sb_z: z_out=%h required %h", z_out, e.z);
                    else n_pass++;
                    n_total++;
                    if (busy_cnt != e.lat) $display("FAIL sb_latency: busy cycles=%0d required %0d", busy_cnt, e.lat);
                    else n_pass++;
                end
                busy_cnt = 0;
            end
            prev_done  = done;
            prev_busy  = busy;
            prev_owner = owner;
        end
    end

    task automatic wait_drain();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        n_total++;
        if (k == 100) begin
            $display("FAIL drain_timeout: %0d results outstanding, busy=%b", sb.size(), busy);
            sb.delete();
        end else n_pass++;
    endtask

    task automatic run_single(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        int k;
        @(negedge clk);
        a_in[7:0] = a;
        b_in[7:0] = b;
        c_in[7:0] = c;
        req = 2'b01;
        sb.push_back(model(0, a, b, c));
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        req = 2'b00;
        a_in = '1;
        b_in = '1;
        c_in = '1;
        n_total++;
        if (k == 20) begin
            $display("FAIL grant_timeout: busy=%b required 1", busy);
            sb.delete();
        end else n_pass++;
        wait_drain();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({gnt, busy, done, hit, owner, z_out} !== '0)
            $display("FAIL reset_outputs: gnt=%b busy=%b done=%b hit=%b owner=%0d z=%h required all 0",
                     gnt, busy, done, hit, owner, z_out);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL idle_no_req: busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk);
        a_in[7:0] = 8'd1;
        b_in[7:0] = 8'd0;
        c_in[7:0] = 8'd1;
        req = 2'b01;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid: gnt=%b busy=%b done=%b required 00/0/0", gnt, busy, done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || z_out !== 8'd0)
            $display("FAIL reset_mid_idle: busy=%b z=%h required 0/00", busy, z_out);
        else n_pass++;
    endtask

    task automatic test_hit();         run_single(8'd1, 8'd0, 8'd1);   endtask
    task automatic test_no_hit();      run_single(8'd0, 8'd0, 8'd5);   endtask
    task automatic test_short_path();  run_single(8'd0, 8'd9, 8'd7);   endtask
    task automatic test_wrap();        run_single(8'd1, 8'd0, 8'hFF);  endtask
    task automatic test_b_edge();      run_single(8'd1, 8'd5, 8'd1);   endtask

    task automatic test_round_robin();
        int k, grants;
        logic pb;
        apply_reset();
        a_in = {8'd0, 8'd1};
        b_in = {8'd9, 8'd0};
        c_in = {8'd3, 8'd1};
        for (int j = 0; j < 4; j++)
            sb.push_back(model(j % 2, a_in[(j%2)*8 +: 8], b_in[(j%2)*8 +: 8], c_in[(j%2)*8 +: 8]));
        req = 2'b11;
        grants = 0;
        pb = 1'b0;
        for (k = 0; k < 200 && grants < 4; k++) begin
            @(negedge clk);
            if (busy && !pb) grants++;
            pb = busy;
            if (grants == 4) req = 2'b00;
        end
        req = 2'b00;
        n_total++;
        if (grants != 4) $display("FAIL rr_grants: grants=%0d required 4", grants);
        else n_pass++;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_hit();
        test_no_hit();
        test_short_path();
        test_wrap();
        test_b_edge();
        test_round_robin();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
